// File: rtl/count_capture_fifo_if.sv
// Capture-FIFO bundle: counter sample inputs, read handshake and status.
// With COUNT_CAPTURE_TIMESTAMP_EN defined the bundle also carries rd_ts.
interface count_capture_fifo_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] cnt_in;
  logic              dir_in;
  logic              cap;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_wrap;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clr_ovf;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  logic [7:0]        rd_ts;

  modport master (
    output cnt_in, dir_in, cap, rd_ready, clr_ovf,
    input  rd_valid, rd_data, rd_wrap, rd_ts, level, full, empty, overflow
  );
  modport slave (
    input  cnt_in, dir_in, cap, rd_ready, clr_ovf,
    output rd_valid, rd_data, rd_wrap, rd_ts, level, full, empty, overflow
  );
`else
  modport master (
    output cnt_in, dir_in, cap, rd_ready, clr_ovf,
    input  rd_valid, rd_data, rd_wrap, level, full, empty, overflow
  );
  modport slave (
    input  cnt_in, dir_in, cap, rd_ready, clr_ovf,
    output rd_valid, rd_data, rd_wrap, level, full, empty, overflow
  );
`endif
endinterface

// File: rtl/count_capture_fifo.sv
// Samples the upstream counter on cap, tags wraps since the last sample, buffers in a show-ahead FIFO.
// Optional COUNT_CAPTURE_TIMESTAMP_EN adds an 8-bit free-running timestamp per entry (rd_ts).
module count_capture_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8
) (
  input logic                 CLK,
  input logic                 reset_n,
  count_capture_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = DATA_W + 1 + 8;
`else
  localparam int unsigned ENTRY_W = DATA_W + 1;
`endif
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  ONE_LVL  = LVL_W'(1);
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  logic [DATA_W-1:0]  prev_cnt_q;
  logic               prev_valid_q;
  logic               wrap_pend_q, wrap_pend_d;
  logic               ovf_q, ovf_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
  logic [7:0]         ts_q, ts_d;
`endif

  logic               wrap_evt;
  logic               full, empty, valid;
  logic               push, pop, drop;
  logic [ENTRY_W-1:0] push_entry;

  always_comb begin
    wrap_evt = prev_valid_q &&
               (( bus.dir_in && prev_cnt_q == ALL_ONES && bus.cnt_in == '0) ||
                (!bus.dir_in && prev_cnt_q == '0       && bus.cnt_in == ALL_ONES));
    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);
    valid = !empty;
    pop   = valid && bus.rd_ready;
    push  = bus.cap && (!full || pop);
    drop  = bus.cap && full && !pop;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    push_entry = {bus.cnt_in, wrap_pend_q | wrap_evt, ts_q};
    ts_d       = ts_q + 8'd1;
`else
    push_entry = {bus.cnt_in, wrap_pend_q | wrap_evt};
`endif
  end

  always_comb begin
    level_d     = level_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_d      = head_q;
    wrap_pend_d = wrap_pend_q | wrap_evt;
    ovf_d       = ovf_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase
    if (push) begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
      wrap_pend_d = 1'b0;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Head register tracks the next head; bypass the incoming entry when it becomes the head this cycle.
    if ((pop || empty) && level_d != '0) begin
      if (empty || (pop && level_q == ONE_LVL)) head_d = push_entry;
      else                                      head_d = mem_q[rd_ptr_d];
    end

    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      wrap_pend_q  <= 1'b0;
      ovf_q        <= 1'b0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_q       <= '0;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
      ts_q         <= '0;
`endif
    end else begin
      prev_cnt_q   <= bus.cnt_in;
      prev_valid_q <= 1'b1;
      wrap_pend_q  <= wrap_pend_d;
      ovf_q        <= ovf_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_q       <= head_d;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
      ts_q         <= ts_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    bus.rd_valid = valid;
    bus.rd_data  = head_q[ENTRY_W-1 -: DATA_W];
    bus.rd_wrap  = head_q[ENTRY_W-1-DATA_W];
    bus.level    = level_q;
    bus.full     = full;
    bus.empty    = empty;
    bus.overflow = ovf_q;
`ifdef COUNT_CAPTURE_TIMESTAMP_EN
    bus.rd_ts    = head_q[7:0];
`endif
  end
endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
Downstream consumer of the 4-bit up/down counter stage. Samples the counter value on a capture strobe and tags each sample with whether the counter wrapped since the previous sample. Buffers the samples in a DEPTH-entry FIFO and hands them out over a valid/ready interface. Lets a slower consumer (logger or bus bridge) read counter history without losing wrap information.

Parameters:
DATA_W, 4, width of the sampled counter value; must match the upstream counter width.
DEPTH, 8, number of FIFO entries; power of 2, at least 2.

Ports:
CLK  in  1  rising-edge clock, shared with the counter stage
reset_n  in  1  asynchronous, active-low reset
cnt_in  in  DATA_W  counter output from the upstream stage
dir_in  in  1  upstream direction control; 1 = counting up, 0 = counting down
cap  in  1  capture strobe; sample cnt_in this cycle
rd_valid  out  1  head entry is available
rd_ready  in  1  consumer accepts the head entry
rd_data  out  DATA_W  head entry count value
rd_wrap  out  1  head entry wrap tag
level  out  $clog2(DEPTH)+1  current number of entries
full  out  1  level == DEPTH
empty  out  1  level == 0
overflow  out  1  sticky; a capture was dropped
clr_ovf  in  1  clears overflow

Behaviour:
- Reset (asynchronous assert, synchronous release): FIFO empty, level=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_wrap=0, overflow=0, wrap-pending=0, prev-valid=0.
- Previous-value register:
  - prev_cnt <= cnt_in every cycle.
  - prev_valid is set on the first cycle after reset release.
- Wrap event. Valid only when prev_valid=1:
  - (dir_in=1 && prev_cnt=all-ones && cnt_in=0) or (dir_in=0 && prev_cnt=0 && cnt_in=all-ones).
  - Other jumps, such as an upstream synchronous reset to 0, are not wraps.
- Wrap-pending flag:
  - Set on a wrap event.
  - Cleared when a capture is accepted.
  - Wrap event and accepted capture in the same cycle: the stored tag = 1 and pending ends at 0.
- Push: cap=1 and (not full, or pop this cycle). Writes {cnt_in, wrap-pending OR wrap event} at the tail.
- Pop: rd_valid && rd_ready. Head advances.
- Show-ahead output:
  - rd_data/rd_wrap reflect the head whenever rd_valid=1.
  - Push into an empty FIFO gives rd_valid=1 on the next cycle (1-cycle latency).
  - When rd_valid=0, rd_data/rd_wrap hold their last value.
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - Full with push and pop in the same cycle: push accepted, level stays at DEPTH.
  - Empty with cap and rd_ready: rd_valid=0, so no pop; push accepted, level=1.
- Overflow:
  - cap=1 while full and no pop: sample dropped, overflow <= 1. Wrap-pending is NOT cleared, so the wrap is reported on the next accepted sample.
  - clr_ovf clears overflow. If clr_ovf coincides with a new drop, set wins.
- Pointers: log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH. Level is held in a separate counter register.
- Reset mid-operation: all entries discarded immediately and outputs return to reset values. Pending wraps are lost.
- No X propagation: storage is not reset, but rd_data is taken from a register that is reset.

Optional Feature:
COUNT_CAPTURE_TIMESTAMP_EN
- Defined:
  - Adds an 8-bit free-running timestamp counter, reset to 0, incrementing every cycle and wrapping 255->0.
  - Each entry stores the timestamp value of the push cycle.
  - New output port rd_ts[7:0] follows the same show-ahead and hold rules as rd_data; reset value 0.
- Undefined: no timestamp counter, storage or rd_ts port; all other behaviour identical.

Test Plan:
- Reset, then cap=1 with cnt_in=5, rd_ready=0 -> next cycle: rd_valid=1, rd_data=5, rd_wrap=0, level=1, empty=0.
- Drive cnt_in 14,15,0 with dir_in=1 (no cap), then cap with cnt_in=1 -> entry rd_data=1, rd_wrap=1. The next capture has rd_wrap=0.
- dir_in=0, cnt_in 0->15 with cap on the wrap cycle -> stored rd_wrap=1, and pending is cleared.
- DEPTH=8: nine caps of values 0..8 with rd_ready=0 -> full=1, level=8, overflow=1. Drain yields 0..7 in order. Pulse clr_ovf -> overflow=0.
- Full FIFO, cap=1 and rd_ready=1 in the same cycle -> level stays 8, overflow stays 0, new value at tail.
- Assert reset_n=0 mid-stream with level=3 -> immediately rd_valid=0, level=0, empty=1, rd_data=0. With COUNT_CAPTURE_TIMESTAMP_EN, rd_ts=0, and after release the first capture 4 cycles later shows rd_ts=4.
